// File: rtl/lfsr_rand_scheduler.sv
// lfsr_rand_scheduler: one 64-bit Fibonacci LFSR shared round-robin among
// N_REQ requesters. The LFSR is warmed up after reset/reseed and advanced
// STRIDE shifts between issued words so consecutive words are decorrelated.
module lfsr_rand_scheduler #(
   parameter int          N_REQ  = 4,
   parameter logic [63:0] SEED   = 64'hFEEDBABEDEADBEEF,
   parameter int          STRIDE = 64,
   parameter int          WARMUP = 128
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [N_REQ-1:0] req_i,
   input  logic             seed_load_i,
   input  logic [63:0]      seed_in_i,
   output logic [N_REQ-1:0] grant_o,
   output logic             rvalid_o,
   output logic [63:0]      rdata_o,
   output logic             busy_o
);

   localparam int CNT_MAX = (WARMUP > STRIDE) ? WARMUP : STRIDE;
   localparam int CW      = $clog2(CNT_MAX + 1);
   localparam int PW      = $clog2(N_REQ);

   // Terminal counts: the step taken while cnt equals these is the last one.
   localparam logic [CW-1:0] WARM_LAST   = (WARMUP > 0) ? CW'(WARMUP - 1) : '0;
   localparam logic [CW-1:0] STRIDE_LAST = CW'(STRIDE - 1);

   typedef enum logic [1:0] {
      ST_WARMUP  = 2'd0,
      ST_READY   = 2'd1,
      ST_ADVANCE = 2'd2
   } state_e;

   // With no warm-up requested, reset and reseed land directly in READY.
   localparam state_e ST_START = (WARMUP == 0) ? ST_READY : ST_WARMUP;

   state_e           state_q;
   logic [CW-1:0]    cnt_q;
   logic [63:0]      lfsr_q;
   logic [PW-1:0]    ptr_q;
   logic [N_REQ-1:0] grant_q;
   logic             rvalid_q;
   logic [63:0]      rdata_q;

   logic [63:0]      lfsr_d;
   logic             win_valid;
   logic [PW-1:0]    win_idx;
   logic [N_REQ-1:0] win_onehot;
   logic [PW-1:0]    ptr_d;

   assign lfsr_d = {lfsr_q[62:0], lfsr_q[63] ^ lfsr_q[62] ^ lfsr_q[60] ^ lfsr_q[59]};

   // Rotating priority scan: first active request at or after ptr, wrapping.
   always_comb begin : arb_scan
      int idx;
      win_valid  = 1'b0;
      win_idx    = '0;
      win_onehot = '0;
      idx        = 0;
      for (int k = 0; k < N_REQ; k++) begin
         idx = (int'(ptr_q) + k) % N_REQ;
         if (!win_valid && req_i[idx]) begin
            win_valid = 1'b1;
            win_idx   = PW'(idx);
         end
      end
      win_onehot[win_idx] = win_valid;
      ptr_d = (win_idx == PW'(N_REQ - 1)) ? '0 : win_idx + PW'(1);
   end

   // Scheduler FSM: warm-up, wait for a request, then stride the LFSR.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= ST_START;
         cnt_q    <= '0;
         lfsr_q   <= SEED;
         ptr_q    <= '0;
         grant_q  <= '0;
         rvalid_q <= 1'b0;
         rdata_q  <= '0;
      end else begin
         grant_q  <= '0;
         rvalid_q <= 1'b0;
         if (seed_load_i) begin
            // Reseed wins over everything; an all-zero seed would lock up.
            lfsr_q  <= (seed_in_i == 64'd0) ? SEED : seed_in_i;
            state_q <= ST_START;
            cnt_q   <= '0;
         end else begin
            case (state_q)
               ST_WARMUP: begin
                  lfsr_q <= lfsr_d;
                  if (cnt_q == WARM_LAST) begin
                     state_q <= ST_READY;
                     cnt_q   <= '0;
                  end else begin
                     cnt_q <= cnt_q + CW'(1);
                  end
               end
               ST_READY: begin
                  if (win_valid) begin
                     grant_q  <= win_onehot;
                     rvalid_q <= 1'b1;
                     rdata_q  <= lfsr_q;
                     ptr_q    <= ptr_d;
                     cnt_q    <= '0;
                     state_q  <= ST_ADVANCE;
                  end
               end
               ST_ADVANCE: begin
                  lfsr_q <= lfsr_d;
                  if (cnt_q == STRIDE_LAST) begin
                     state_q <= ST_READY;
                     cnt_q   <= '0;
                  end else begin
                     cnt_q <= cnt_q + CW'(1);
                  end
               end
               default: begin
                  state_q <= ST_START;
                  cnt_q   <= '0;
               end
            endcase
         end
      end
   end

   assign grant_o  = grant_q;
   assign rvalid_o = rvalid_q;
   assign rdata_o  = rdata_q;
   assign busy_o   = (state_q != ST_READY);

endmodule

// File: tb/tb_lfsr_rand_scheduler.sv
// Testbench for lfsr_rand_scheduler: directed scenarios plus randomized
// request/reseed traffic, checked every cycle against a transaction-level model.
module tb_lfsr_rand_scheduler;

   localparam int          N_REQ  = 4;
   localparam int          STRIDE = 4;
   localparam int          WARMUP = 8;
   localparam logic [63:0] SEED   = 64'hFEEDBABEDEADBEEF;

   logic             clk;
   logic             rst_n;
   logic [N_REQ-1:0] req;
   logic             seed_load;
   logic [63:0]      seed_in;
   logic [N_REQ-1:0] grant;
   logic             rvalid;
   logic [63:0]      rdata;
   logic             busy;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state: current seed, number of words issued since seed,
   // cycles left before the next word may be issued, rotation pointer.
   logic [63:0]      m_seed;
   int               m_k;
   int               m_wait;
   int               m_ptr;
   logic [N_REQ-1:0] m_grant;
   logic             m_rvalid;
   logic [63:0]      m_rdata;

   lfsr_rand_scheduler #(
      .N_REQ (N_REQ),
      .SEED  (SEED),
      .STRIDE(STRIDE),
      .WARMUP(WARMUP)
   ) dut (
      .clk_i      (clk),
      .rst_ni     (rst_n),
      .req_i      (req),
      .seed_load_i(seed_load),
      .seed_in_i  (seed_in),
      .grant_o    (grant),
      .rvalid_o   (rvalid),
      .rdata_o    (rdata),
      .busy_o     (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Software LFSR: advance a state n times with the feedback taps 63,62,60,59.
   function automatic logic [63:0] lfsr_adv(input logic [63:0] s, input int n);
      logic [63:0] v;
      v = s;
      for (int i = 0; i < n; i++) v = {v[62:0], v[63] ^ v[62] ^ v[60] ^ v[59]};
      return v;
   endfunction

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s t=%0t got=%h exp=%h", tag, $time, got, exp);
      end
   endtask

   task automatic model_reset();
      m_seed   = SEED;
      m_k      = 0;
      m_wait   = WARMUP;
      m_ptr    = 0;
      m_grant  = '0;
      m_rvalid = 1'b0;
      m_rdata  = '0;
   endtask

   // One clock edge of the model, using the inputs the DUT sampled.
   task automatic model_edge();
      int w;
      m_grant  = '0;
      m_rvalid = 1'b0;
      if (seed_load) begin
         m_seed = (seed_in == 64'd0) ? SEED : seed_in;
         m_k    = 0;
         m_wait = WARMUP;
      end else if (m_wait > 0) begin
         m_wait--;
      end else if (|req) begin
         w = -1;
         for (int k = 0; k < N_REQ; k++)
            if (w < 0 && req[(m_ptr + k) % N_REQ]) w = (m_ptr + k) % N_REQ;
         m_grant  = N_REQ'(1) << w;
         m_rvalid = 1'b1;
         m_rdata  = lfsr_adv(m_seed, WARMUP + m_k * STRIDE);
         m_k++;
         m_ptr    = (w + 1) % N_REQ;
         m_wait   = STRIDE;
      end
   endtask

   task automatic compare_all();
      check_eq("grant",  64'(grant),  64'(m_grant));
      check_eq("rvalid", 64'(rvalid), 64'(m_rvalid));
      check_eq("rdata",  rdata,       m_rdata);
      check_eq("busy",   64'(busy),   64'(m_wait > 0));
   endtask

   // Called at a negedge: drive inputs, advance one edge, compare at next negedge.
   task automatic drive_cycle(input logic [N_REQ-1:0] r, input logic sl, input logic [63:0] si);
      req       = r;
      seed_load = sl;
      seed_in   = si;
      @(posedge clk);
      model_edge();
      @(negedge clk);
      compare_all();
      if (m_rvalid)
         $display("txn t=%0t grant=%b rdata=%h (dut grant=%b rdata=%h)", $time, m_grant, m_rdata, grant, rdata);
   endtask

   // Hold a request pattern until the model issues a word, bounded.
   task automatic run_until_grant(input logic [N_REQ-1:0] r, input int limit);
      int n;
      n = 0;
      do begin
         drive_cycle(r, 1'b0, 64'd0);
         n++;
      end while (!m_rvalid && n < limit);
      if (!m_rvalid) check_eq("grant_timeout", 64'd0, 64'd1);
   endtask

   initial begin
      rst_n     = 1'b0;
      req       = '0;
      seed_load = 1'b0;
      seed_in   = '0;
      model_reset();
      repeat (2) @(negedge clk);
      compare_all();
      rst_n = 1'b1;

      // Scenario 1: single requester, warm-up then grants every STRIDE+1 cycles.
      repeat (30) drive_cycle(4'b0001, 1'b0, 64'd0);

      // Scenario 2: all requesters, full rotation.
      repeat (30) drive_cycle(4'b1111, 1'b0, 64'd0);

      // Scenario 3: set ptr to 2, then 1001 -> 1000 then 0001.
      run_until_grant(4'b0010, 20);
      repeat (12) drive_cycle(4'b1001, 1'b0, 64'd0);
      // Set ptr to 2 again, then drop req[3] before READY.
      run_until_grant(4'b0010, 20);
      repeat (2) drive_cycle(4'b1001, 1'b0, 64'd0);
      repeat (6) drive_cycle(4'b0001, 1'b0, 64'd0);

      // Scenario 4a: reseed with zero selects the default seed.
      drive_cycle(4'b0001, 1'b1, 64'd0);
      repeat (20) drive_cycle(4'b0001, 1'b0, 64'd0);

      // Scenario 4b: reseed with 1 during ADVANCE.
      run_until_grant(4'b0001, 20);
      drive_cycle(4'b0001, 1'b1, 64'd1);
      repeat (20) drive_cycle(4'b0001, 1'b0, 64'd0);

      // Scenario 5: reseed on the very edge a grant would happen.
      run_until_grant(4'b1111, 20);
      repeat (STRIDE) drive_cycle(4'b1111, 1'b0, 64'd0);
      drive_cycle(4'b1111, 1'b1, 64'h0123456789ABCDEF);
      repeat (15) drive_cycle(4'b1111, 1'b0, 64'd0);

      // Scenario 6: asynchronous reset while a grant is on the outputs.
      run_until_grant(4'b1111, 20);
      #1 rst_n = 1'b0;
      #1;
      check_eq("async_grant",  64'(grant),  64'd0);
      check_eq("async_rvalid", 64'(rvalid), 64'd0);
      check_eq("async_rdata",  rdata,       64'd0);
      check_eq("async_busy",   64'(busy),   64'd1);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      repeat (30) drive_cycle(4'b0001, 1'b0, 64'd0);

      // Scenario 7: randomized requests with occasional reseeds.
      for (int i = 0; i < 400; i++) begin
         logic             sl;
         logic [63:0]      si;
         logic [N_REQ-1:0] r;
         r  = N_REQ'($urandom_range(0, 15));
         sl = ($urandom_range(0, 49) == 0);
         si = ($urandom_range(0, 3) == 0) ? 64'd0 : {$urandom, $urandom};
         drive_cycle(r, sl, si);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
